// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the seq_gen serial pattern transmitter.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  localparam logic [7:0] LFSR_TAPS       = 8'hB8;
  localparam logic [2:0] DEFAULT_PATTERN = 3'b101;

endpackage

// File: rtl/seq_gen_if.sv
// Request/stream bundle between a requester (master) and seq_gen (slave).
interface seq_gen_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap_len;
  logic             ready;
  logic             busy;
  logic             out_bit;
  logic             out_valid;
  logic             frame_start;
  logic             done;

  modport master (
    output start, pattern, repeat_n, gap_len,
    input  ready, busy, out_bit, out_valid, frame_start, done
  );

  modport slave (
    input  start, pattern, repeat_n, gap_len,
    output ready, busy, out_bit, out_valid, frame_start, done
  );

endinterface

// File: rtl/seq_lfsr.sv
// 8-bit Fibonacci LFSR with enable; exposes current and next low bit.
module seq_lfsr
  import seq_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic cur_bit,
  output logic next_bit
);

  logic [7:0] value;
  logic [7:0] next_value;

  assign next_value = {value[6:0], ^(value & LFSR_TAPS)};
  assign cur_bit    = value[0];
  assign next_bit   = next_value[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= SEED;
    end else if (en) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: MSB-first copies of a latched pattern with gaps.
// Define SEQ_GEN_LFSR_EN to fill gap cycles with valid LFSR noise bits.
module seq_gen
  import seq_pkg::*;
#(
  parameter int         PAT_W     = 3,
  parameter int         CNT_W     = 8,
  parameter int         GAP_W     = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic      clk,
  input logic      rst,
  seq_gen_if.slave bus
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] copies_q, copies_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [PAT_W-1:0] pat_q, pat_d;

  logic ready_q, busy_q, out_bit_q, out_valid_q, frame_start_q, done_q;
  logic ready_d, out_bit_d, out_valid_d, frame_start_d, done_d;

`ifdef SEQ_GEN_LFSR_EN
  logic lfsr_cur, lfsr_next, gap_bit;

  seq_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == GAP),
    .cur_bit  (lfsr_cur),
    .next_bit (lfsr_next)
  );

  // Outputs are registered from the next state, so a GAP cycle shows the
  // value the LFSR will hold during that cycle.
  assign gap_bit = (state_q == GAP) ? lfsr_next : lfsr_cur;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    copies_d  = copies_q;
    gap_cnt_d = gap_cnt_q;
    gap_len_d = gap_len_q;
    pat_d     = pat_q;

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (bus.start) begin
          pat_d     = bus.pattern;
          gap_len_d = bus.gap_len;
          copies_d  = bus.repeat_n;
          idx_d     = IDX_TOP;
          gap_cnt_d = '0;
          state_d   = (bus.repeat_n == '0) ? FIN : SEND;
        end
      end
      SEND: begin
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          copies_d = copies_q - 1'b1;
          if (copies_q > CNT_W'(1)) begin
            idx_d = IDX_TOP;
            if (gap_len_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_len_q;
            end
          end else begin
            state_d = FIN;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d   = SEND;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d       = (state_d == IDLE) || (state_d == FIN);
    done_d        = (state_d == FIN);
    out_valid_d   = (state_d == SEND);
    out_bit_d     = (state_d == SEND) ? pat_d[idx_d] : 1'b0;
    frame_start_d = (state_d == SEND) && (idx_d == IDX_TOP);
`ifdef SEQ_GEN_LFSR_EN
    if (state_d == GAP) begin
      out_valid_d = 1'b1;
      out_bit_d   = gap_bit;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      copies_q      <= '0;
      gap_cnt_q     <= '0;
      gap_len_q     <= '0;
      pat_q         <= PAT_W'(DEFAULT_PATTERN);
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      copies_q      <= copies_d;
      gap_cnt_q     <= gap_cnt_d;
      gap_len_q     <= gap_len_d;
      pat_q         <= pat_d;
      ready_q       <= ready_d;
      busy_q        <= ~ready_d;
      out_bit_q     <= out_bit_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;
  assign bus.out_bit     = out_bit_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: a request-level model expands each request
// into the expected per-cycle output stream {ready,busy,valid,bit,frame_start,done}.
module tb_seq_gen;
  import seq_pkg::*;

  localparam int PW = 3;
  localparam logic [5:0] OBS_IDLE = 6'b100000;
  localparam logic [5:0] OBS_FIN  = 6'b100001;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  logic [5:0] exp_q[$];
  logic       vbits[$];
  int         busy_cnt;

`ifdef SEQ_GEN_LFSR_EN
  logic [7:0] lfsr_m = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction
`endif

  seq_gen_if #(.PAT_W(PW), .CNT_W(8), .GAP_W(4)) bus ();

  seq_gen #(.PAT_W(PW), .CNT_W(8), .GAP_W(4), .LFSR_SEED(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] sample();
    return {bus.ready, bus.busy, bus.out_valid, bus.out_bit, bus.frame_start, bus.done};
  endfunction

  // Expand one request into its output stream: copies MSB first, gaps only
  // between copies, then one FIN cycle.
  task automatic build_expected(input logic [PW-1:0] p, input int n, input int g);
    for (int c = 0; c < n; c++) begin
      for (int b = PW - 1; b >= 0; b--)
        exp_q.push_back({1'b0, 1'b1, 1'b1, p[b], (b == PW - 1), 1'b0});
      if (c < n - 1) begin
        for (int k = 0; k < g; k++) begin
`ifdef SEQ_GEN_LFSR_EN
          exp_q.push_back({1'b0, 1'b1, 1'b1, lfsr_m[0], 2'b00});
          lfsr_m = lfsr_step(lfsr_m);
`else
          exp_q.push_back(6'b010000);
`endif
        end
      end
    end
    exp_q.push_back(OBS_FIN);
  endtask

  // Issue one request, scribble on the inputs while busy, optionally pulse
  // start at stream index poke_at, and check every cycle plus busy length.
  task automatic run_request(input logic [PW-1:0] p, input int n, input int g,
                             input int poke_at, input string name);
    logic [5:0] obs;
    int exp_busy;
    exp_q.delete();
    vbits.delete();
    build_expected(p, n, g);
    exp_busy = n * PW + ((n > 0) ? (n - 1) * g : 0);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.pattern  = p;
    bus.repeat_n = 8'(n);
    bus.gap_len  = 4'(g);
    @(posedge clk);
    #1;
    busy_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      bus.start    = (i == poke_at);
      bus.pattern  = PW'($urandom);
      bus.repeat_n = 8'($urandom_range(1, 9));
      bus.gap_len  = 4'($urandom);
      obs = sample();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL %s cyc%0d: got %b want %b (rdy,bsy,val,bit,fs,done)",
                 name, i, obs, exp_q[i]);
      end
      if (obs[4]) busy_cnt++;
      if (obs[3]) vbits.push_back(obs[2]);
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    obs = sample();
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("[TB] FAIL %s idle_after: got %b want %b", name, obs, OBS_IDLE);
    end
    checks++;
    if (busy_cnt != exp_busy) begin
      errors++;
      $display("[TB] FAIL %s busy_len: got %0d want %0d", name, busy_cnt, exp_busy);
    end
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pattern = '0;
    bus.repeat_n = '0;
    bus.gap_len = '0;
    #2 rst = 1'b0;
    #1;
    obs = sample();
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("[TB] FAIL reset_initial: got %b want %b", obs, OBS_IDLE);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Abort a long request partway through the first copy.
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = 3'b110;
    bus.repeat_n = 8'd4;
    bus.gap_len = 4'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    obs = sample();
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("[TB] FAIL reset_async_abort: got %b want %b", obs, OBS_IDLE);
    end
`ifdef SEQ_GEN_LFSR_EN
    lfsr_m = 8'hA5;
`endif
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      obs = sample();
      checks++;
      if (obs !== OBS_IDLE) begin
        errors++;
        $display("[TB] FAIL reset_release cyc%0d: got %b want %b", i, obs, OBS_IDLE);
      end
    end
  endtask

  task automatic test_single();
    run_request(3'b101, 1, 0, -1, "single");
  endtask

  task automatic test_gap();
    int hits;
    run_request(3'b101, 3, 2, -1, "gap");
    hits = 0;
    for (int j = 0; j + 2 < vbits.size(); j++)
      if (vbits[j] && !vbits[j+1] && vbits[j+2]) hits++;
`ifndef SEQ_GEN_LFSR_EN
    checks++;
    if (hits != 3) begin
      errors++;
      $display("[TB] FAIL gap_detect101: got %0d want 3", hits);
    end
`endif
  endtask

  task automatic test_zero();
    run_request(3'b111, 0, 3, -1, "zero_repeat");
  endtask

  task automatic test_ignore_start();
    run_request(3'b101, 2, 1, 1, "ignore_start");
  endtask

  task automatic test_max_gap();
    run_request(3'b011, 2, 15, -1, "max_gap");
  endtask

  // Start held high through FIN launches the second request immediately.
  task automatic test_back_to_back();
    logic [5:0] obs;
    int len_a;
    exp_q.delete();
    build_expected(3'b101, 2, 0);
    len_a = exp_q.size();
    build_expected(3'b010, 2, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = 3'b101;
    bus.repeat_n = 8'd2;
    bus.gap_len = 4'd0;
    @(posedge clk);
    #1;
    bus.pattern = 3'b010;
    bus.gap_len = 4'd1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == len_a) bus.start = 1'b0;
      obs = sample();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
    end
    @(posedge clk);
    #1;
    obs = sample();
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("[TB] FAIL back_to_back idle_after: got %b want %b", obs, OBS_IDLE);
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] p;
    int n, g, poke;
    for (int t = 0; t < 10; t++) begin
      p = PW'($urandom);
      n = $urandom_range(0, 4);
      g = ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 3);
      poke = (n > 0) ? $urandom_range(0, 2) : -1;
      run_request(p, n, g, poke, "random");
    end
  endtask

`ifdef SEQ_GEN_LFSR_EN
  task automatic test_lfsr();
    @(negedge clk) rst = 1'b0;
    lfsr_m = 8'hA5;
    @(negedge clk) rst = 1'b1;
    run_request(3'b101, 2, 4, -1, "lfsr");
    checks++;
    if (vbits.size() != 10) begin
      errors++;
      $display("[TB] FAIL lfsr_valid_run: got %0d want 10", vbits.size());
    end else begin
      checks++;
      if ({vbits[3], vbits[4], vbits[5], vbits[6]} !== 4'b1010) begin
        errors++;
        $display("[TB] FAIL lfsr_gap_bits: got %b want 1010",
                 {vbits[3], vbits[4], vbits[5], vbits[6]});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_zero();
    test_ignore_start();
    test_back_to_back();
    test_max_gap();
    test_random();
`ifdef SEQ_GEN_LFSR_EN
    test_lfsr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
